cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 reset  in  1  async active-high reset.
REQ-004 i_read  in  1  instruction-cache line-fill request.
REQ-005 i_address  in  16  instruction line address, held stable while i_read is high.
REQ-006 i_rdata  out  128  line data to instruction cache.
REQ-007 i_resp  out  1  one-cycle completion pulse to instruction cache.
REQ-008 d_read  in  1  data-cache line-fill request.
REQ-009 d_write  in  1  data-cache write-back request.
REQ-010 d_address  in  16  data line address, held stable while a request is high.
REQ-011 d_wdata  in  128  write-back line.
REQ-012 d_rdata  out  128  line data to data cache.
REQ-013 d_resp  out  1  one-cycle completion pulse to data cache.
REQ-014 pmem_read  out  1  physical memory read strobe.
REQ-015 pmem_write  out  1  physical memory write strobe.
REQ-016 pmem_address  out  16  physical memory address.
REQ-017 pmem_wdata  out  128  physical memory write line.
REQ-018 pmem_rdata  in  128  physical memory read line.
REQ-019 pmem_resp  in  1  physical memory completion, valid one cycle.

Function
REQ-020 States: IDLE, SERVE_I, SERVE_D; plus 1-bit register last_grant (I or D).
REQ-021 IDLE: all pmem strobes 0, i_resp = d_resp = 0; pmem_resp ignored.
REQ-022 IDLE, only I requests: next state SERVE_I.
REQ-023 IDLE, only D requests (d_read or d_write): next state SERVE_D.
REQ-024 IDLE, both request: grant the client other than last_grant; last_grant updated on every grant edge.
REQ-025 SERVE_I: pmem_read = i_read, pmem_write = 0, pmem_address = i_address, combinational passthrough.
REQ-026 SERVE_D: pmem_address = d_address, pmem_wdata = d_wdata; if d_write high, pmem_write = 1 and pmem_read = 0; otherwise pmem_read = d_read.
REQ-027 d_read and d_write both high is illegal; the arbiter forwards the write only (REQ-026).
REQ-028 In SERVE_x with pmem_resp = 1: x_resp = 1 in the same cycle, next state IDLE.
REQ-029 i_rdata and d_rdata are wired to pmem_rdata at all times; only the resp signals qualify them.
REQ-030 The non-granted client's resp stays 0 for the whole grant, regardless of its request.
REQ-031 Served client drops its request before pmem_resp: strobes drop the same cycle, next state IDLE, no resp issued.
REQ-032 Mandatory one-cycle IDLE between grants; a client still requesting after its resp is re-arbitrated there (covers the write-back then read-fill sequence).
REQ-033 Latency: request to pmem strobe is 1 cycle from IDLE; pmem_resp to client resp is 0 cycles.
REQ-034 pmem_address and pmem_wdata are 0 in IDLE.

Reset
REQ-035 On reset assertion: state = IDLE and last_grant = D immediately, without waiting for a clock edge, so I wins the first tie.
REQ-036 On reset, all outputs take their IDLE values combinationally, including during an in-flight SERVE state; the transaction is abandoned and no resp is issued.
REQ-037 Reset deassertion takes effect at the next rising edge; the first arbitration occurs that edge.

Verification
REQ-038 Scenario 1: i_read=1, i_address=0x1230, pmem_resp after 3 cycles with rdata=0xA5..A5 -> pmem_read high from cycle 1, i_resp pulse with i_rdata=0xA5..A5, d_resp stays 0.
REQ-039 Scenario 2: after reset, i_read and d_read asserted together -> I granted first; after its resp, D granted following one IDLE cycle; next simultaneous tie -> I granted again (last_grant = D).
REQ-040 Scenario 3: d_write=1, d_address=0x4560, d_wdata=0x1111..; on resp d_write drops and d_read rises -> pmem_write then IDLE then pmem_read at 0x4560, two d_resp pulses total.
REQ-041 Scenario 4: reset asserted mid-SERVE_D with pmem_write high -> pmem_write 0 within the same cycle, no d_resp, state IDLE.
REQ-042 Scenario 5: pmem_resp pulsed while in IDLE -> no i_resp/d_resp, no state change.
REQ-043 Scenario 6: i_read dropped in SERVE_I before pmem_resp -> pmem_read 0 that cycle, IDLE next, no i_resp.

Source files
------------

// File: rtl/cache_arbiter.sv
// Two-client line-fill/write-back arbiter in front of a single physical memory port.
// Alternates grants on simultaneous requests and returns to IDLE for one cycle after every grant.
module cache_arbiter (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_read,
  input  logic [15:0]  i_address,
  output logic [127:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [15:0]  d_address,
  input  logic [127:0] d_wdata,
  output logic [127:0] d_rdata,
  output logic         d_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t state_reg;
  logic   last_grant_reg;
  logic   i_req;
  logic   d_req;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // I wins a tie only when D held the previous grant; reset leaves D as last so I wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_D;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_req && (!d_req || last_grant_reg == GRANT_D)) begin
            state_reg      <= SERVE_I;
            last_grant_reg <= GRANT_I;
          end else if (d_req) begin
            state_reg      <= SERVE_D;
            last_grant_reg <= GRANT_D;
          end
        end
        SERVE_I: if (!i_req || pmem_resp) state_reg <= IDLE;
        SERVE_D: if (!d_req || pmem_resp) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Memory side is a combinational passthrough of the granted client; reset forces IDLE values.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 16'h0000;
    pmem_wdata   = 128'h0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    if (!reset) begin
      case (state_reg)
        SERVE_I: begin
          pmem_read    = i_read;
          pmem_address = i_address;
          i_resp       = i_read & pmem_resp;
        end
        SERVE_D: begin
          pmem_address = d_address;
          pmem_wdata   = d_wdata;
          pmem_write   = d_write;
          pmem_read    = d_read & ~d_write;
          d_resp       = d_req & pmem_resp;
        end
        default: ;
      endcase
    end
  end

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios followed by random traffic, all checked
// against a transaction-level model of who owns the memory port each cycle.
module tb_cache_arbiter;

  logic         clk;
  logic         reset;
  logic         i_read;
  logic [15:0]  i_address;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  cache_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int NONE = 0;
  localparam int OWN_I = 1;
  localparam int OWN_D = 2;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: which client currently owns the port, and whether D was the most recent grantee.
  int m_owner  = NONE;
  bit m_last_d = 1'b1;
  bit m_i_resp_prev = 1'b0;
  bit m_d_resp_prev = 1'b0;

  int obs_i_resps = 0;
  int obs_d_resps = 0;

  logic         stim_i_read, stim_d_read, stim_d_write, stim_pmem_resp;
  logic [15:0]  stim_i_address, stim_d_address;
  logic [127:0] stim_d_wdata, stim_pmem_rdata;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pmem_read"},  128'(pmem_read),    128'(0));
    check({tag, "_pmem_write"}, 128'(pmem_write),   128'(0));
    check({tag, "_pmem_addr"},  128'(pmem_address), 128'(0));
    check({tag, "_pmem_wdata"}, pmem_wdata,         128'(0));
    check({tag, "_i_resp"},     128'(i_resp),       128'(0));
    check({tag, "_d_resp"},     128'(d_resp),       128'(0));
  endtask

  task automatic clear_stim();
    stim_i_read = 0; stim_d_read = 0; stim_d_write = 0; stim_pmem_resp = 0;
    stim_i_address = '0; stim_d_address = '0; stim_d_wdata = '0; stim_pmem_rdata = '0;
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, optionally pulse reset, advance model.
  task automatic step(input bit do_reset);
    bit i_req, d_req, e_pr, e_pw, e_ir, e_dr;
    logic [15:0]  e_addr;
    logic [127:0] e_wdata;
    @(negedge clk);
    reset      = 1'b0;
    i_read     = stim_i_read;    i_address = stim_i_address;
    d_read     = stim_d_read;    d_write   = stim_d_write;
    d_address  = stim_d_address; d_wdata   = stim_d_wdata;
    pmem_resp  = stim_pmem_resp; pmem_rdata = stim_pmem_rdata;
    #1;
    i_req = stim_i_read;
    d_req = stim_d_read | stim_d_write;
    e_pr = 0; e_pw = 0; e_ir = 0; e_dr = 0; e_addr = '0; e_wdata = '0;
    if (m_owner == OWN_I) begin
      e_pr = i_req; e_addr = stim_i_address; e_ir = i_req & stim_pmem_resp;
    end else if (m_owner == OWN_D) begin
      e_addr = stim_d_address; e_wdata = stim_d_wdata;
      e_pw = stim_d_write; e_pr = stim_d_read & !stim_d_write;
      e_dr = d_req & stim_pmem_resp;
    end
    check("pmem_read",    128'(pmem_read),    128'(e_pr));
    check("pmem_write",   128'(pmem_write),   128'(e_pw));
    check("pmem_address", 128'(pmem_address), 128'(e_addr));
    if (m_owner != OWN_I) check("pmem_wdata", pmem_wdata, e_wdata);
    check("i_resp",  128'(i_resp), 128'(e_ir));
    check("d_resp",  128'(d_resp), 128'(e_dr));
    check("i_rdata", i_rdata, stim_pmem_rdata);
    check("d_rdata", d_rdata, stim_pmem_rdata);
    if (i_resp) obs_i_resps++;
    if (d_resp) obs_d_resps++;
    if (e_ir) $display("txn I read  addr=%h rdata=%h", stim_i_address, stim_pmem_rdata);
    if (e_dr) $display("txn D %s addr=%h", stim_d_write ? "write" : "read ", stim_d_address);
    m_i_resp_prev = e_ir;
    m_d_resp_prev = e_dr;
    if (do_reset) begin
      #1 reset = 1'b1;
      #1;
      check_idle_outputs("reset");
      $display("txn reset asserted mid-cycle");
      m_owner  = NONE;
      m_last_d = 1'b1;
      m_i_resp_prev = 0;
      m_d_resp_prev = 0;
    end else begin
      case (m_owner)
        NONE: begin
          if (i_req && d_req) m_owner = m_last_d ? OWN_I : OWN_D;
          else if (i_req)     m_owner = OWN_I;
          else if (d_req)     m_owner = OWN_D;
          if (m_owner != NONE) m_last_d = (m_owner == OWN_D);
        end
        OWN_I: if (!i_req || stim_pmem_resp) m_owner = NONE;
        default: if (!d_req || stim_pmem_resp) m_owner = NONE;
      endcase
    end
    @(posedge clk);
  endtask

  // Random client behaviour: addresses change only while idle; requests persist or drop after resp.
  task automatic rand_stim(output bit do_reset);
    if (!stim_i_read) begin
      if ($urandom_range(0, 99) < 30) begin
        stim_i_read = 1; stim_i_address = 16'($urandom);
      end
    end else if (m_i_resp_prev) begin
      if ($urandom_range(0, 1) == 0) stim_i_read = 0;
    end else if ($urandom_range(0, 99) < 4) stim_i_read = 0;

    if (!(stim_d_read | stim_d_write)) begin
      if ($urandom_range(0, 99) < 30) begin
        int kind = int'($urandom_range(0, 19));
        stim_d_read  = (kind < 9)  || (kind >= 18);
        stim_d_write = (kind >= 9);
        stim_d_address = 16'($urandom);
        stim_d_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
    end else if (m_d_resp_prev) begin
      if ($urandom_range(0, 1) == 0) begin stim_d_read = 0; stim_d_write = 0; end
    end else if ($urandom_range(0, 99) < 4) begin
      stim_d_read = 0; stim_d_write = 0;
    end

    stim_pmem_resp  = (m_owner != NONE) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 10);
    stim_pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
    do_reset = ($urandom_range(0, 99) < 1);
  endtask

  initial begin
    bit rst_now;
    clear_stim();
    reset = 1'b1;
    i_read = 0; i_address = '0; d_read = 0; d_write = 0; d_address = '0;
    d_wdata = '0; pmem_rdata = '0; pmem_resp = 0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("por");

    // Scenario 1: single instruction fill with a three-cycle memory latency.
    stim_i_read = 1; stim_i_address = 16'h1230;
    obs_i_resps = 0; obs_d_resps = 0;
    step(0); step(0); step(0);
    stim_pmem_resp = 1; stim_pmem_rdata = {16{8'hA5}};
    step(0);
    clear_stim();
    step(0);
    check("s1_i_resp_count", 128'(obs_i_resps), 128'(1));
    check("s1_d_resp_count", 128'(obs_d_resps), 128'(0));

    // Scenario 2: tie after reset goes to I, then D, then I again.
    step(1);
    stim_i_read = 1; stim_i_address = 16'h0AA0;
    stim_d_read = 1; stim_d_address = 16'h0DD0;
    step(0); step(0);
    stim_pmem_resp = 1; step(0);
    stim_pmem_resp = 0; stim_i_read = 0;
    step(0); step(0);
    stim_pmem_resp = 1; step(0);
    stim_pmem_resp = 0; stim_i_read = 1;
    step(0); step(0);
    check("s2_tie_addr", 128'(pmem_address), 128'(16'h0AA0));
    clear_stim(); step(0); step(0);

    // Scenario 3: write-back followed by a read-fill of the same line.
    obs_d_resps = 0;
    stim_d_write = 1; stim_d_address = 16'h4560; stim_d_wdata = {8{16'h1111}};
    step(0); step(0);
    stim_pmem_resp = 1; step(0);
    stim_pmem_resp = 0; stim_d_write = 0; stim_d_read = 1;
    step(0); step(0);
    stim_pmem_resp = 1; step(0);
    clear_stim(); step(0);
    check("s3_d_resp_count", 128'(obs_d_resps), 128'(2));

    // Scenario 4: reset while a write-back is on the bus.
    obs_d_resps = 0;
    stim_d_write = 1; stim_d_address = 16'h7770; stim_d_wdata = {4{32'hDEADBEEF}};
    step(0); step(0);
    step(1);
    clear_stim(); step(0); step(0);
    check("s4_d_resp_count", 128'(obs_d_resps), 128'(0));

    // Scenario 5: stray memory response while idle.
    obs_i_resps = 0; obs_d_resps = 0;
    stim_pmem_resp = 1; step(0); step(0);
    clear_stim(); step(0);
    check("s5_resp_count", 128'(obs_i_resps + obs_d_resps), 128'(0));

    // Scenario 6: instruction request withdrawn before the memory answers.
    stim_i_read = 1; stim_i_address = 16'h2220;
    step(0); step(0);
    stim_i_read = 0; step(0);
    step(0);
    check("s6_i_resp_count", 128'(obs_i_resps), 128'(0));

    for (int n = 0; n < 1500; n++) begin
      rand_stim(rst_now);
      step(rst_now);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
